// File: rtl/roce_mem_read_responder.sv
// rtl/roce_mem_read_responder.sv - RoCE DMA read responder: serves read commands from local memory as a data stream
//
// Accepts one read command at a time ({len, vaddr} plus a dest tag). It reads
// 64B words from a synchronous memory port and returns them in order on the
// memory-read-data stream, with keep, last and dest attached to each beat.
//
// Ports
//   net_clk, net_aresetn          clock, asynchronous active-low reset
//   s_axis_mem_read_cmd_*         command stream (valid/ready, data={len,vaddr}, dest)
//   mem_rd_en/addr, mem_rd_data   memory read port (data returned one cycle after en)
//   m_axis_mem_read_data_*        data stream (valid/ready, data, keep, last, dest)
//   err_count                     saturating count of zero-length or misaligned commands
//   stat_cmd_count/byte_count     completion statistics, present only with ROCE_RD_STATS_EN
//
// Optional feature macro: ROCE_RD_STATS_EN
module roce_mem_read_responder #(
   parameter int DATA_WIDTH  = 512,
   parameter int VADDR_WIDTH = 48,
   parameter int LEN_WIDTH   = 32,
   parameter int DEST_WIDTH  = 4,
   parameter int MEM_AW      = 16
) (
   input  logic                             net_clk,
   input  logic                             net_aresetn,
   input  logic                             s_axis_mem_read_cmd_valid,
   output logic                             s_axis_mem_read_cmd_ready,
   input  logic [VADDR_WIDTH+LEN_WIDTH-1:0] s_axis_mem_read_cmd_data,
   input  logic [DEST_WIDTH-1:0]            s_axis_mem_read_cmd_dest,
   output logic                             mem_rd_en,
   output logic [MEM_AW-1:0]                mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]            mem_rd_data,
   output logic                             m_axis_mem_read_data_valid,
   input  logic                             m_axis_mem_read_data_ready,
   output logic [DATA_WIDTH-1:0]            m_axis_mem_read_data_data,
   output logic [DATA_WIDTH/8-1:0]          m_axis_mem_read_data_keep,
   output logic                             m_axis_mem_read_data_last,
   output logic [DEST_WIDTH-1:0]            m_axis_mem_read_data_dest,
`ifdef ROCE_RD_STATS_EN
   output logic [31:0]                      stat_cmd_count,
   output logic [47:0]                      stat_byte_count,
`endif
   output logic [15:0]                      err_count
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(BYTES);
   localparam int BW    = LEN_WIDTH - OFS + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                  state;
   logic [MEM_AW-1:0]       rd_addr;
   logic [BW-1:0]           reads_left;
   logic [OFS-1:0]          len_mod;
   logic [DEST_WIDTH-1:0]   dest_q;
   logic                    inflight;
   logic                    inflight_last;
   logic [DATA_WIDTH-1:0]   fifo_data [2];
   logic [1:0]              fifo_last;
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              occ;
`ifdef ROCE_RD_STATS_EN
   logic [LEN_WIDTH-1:0]    len_q;
`endif

   logic [VADDR_WIDTH-1:0]  cmd_vaddr;
   logic [LEN_WIDTH-1:0]    cmd_len;
   logic [BW-1:0]           cmd_beats;
   logic                    cmd_accept;
   logic                    unused_vaddr_hi;
   logic [1:0]              used;
   logic                    has_head;
   logic                    head_valid;
   logic                    head_last;
   logic                    pop;
   logic                    push;
   logic                    fifo_pop;
   logic [BYTES-1:0]        keep_last;

   assign cmd_vaddr       = s_axis_mem_read_cmd_data[VADDR_WIDTH-1:0];
   assign cmd_len         = s_axis_mem_read_cmd_data[VADDR_WIDTH +: LEN_WIDTH];
   assign cmd_beats       = BW'(cmd_len[LEN_WIDTH-1:OFS]) + BW'(|cmd_len[OFS-1:0]);
   assign cmd_accept      = s_axis_mem_read_cmd_valid && s_axis_mem_read_cmd_ready;
   // Only the word-address window of vaddr reaches the memory.
   assign unused_vaddr_hi = &{1'b0, cmd_vaddr[VADDR_WIDTH-1:MEM_AW+OFS]};

   // Two slots are shared between buffered words and the word on the memory bus,
   // so nothing returned from memory can ever overflow the skid FIFO.
   assign used        = occ + {1'b0, inflight};
   assign mem_rd_en   = (state == READ) && (used < 2'd2);
   assign mem_rd_addr = rd_addr;

   // With the FIFO empty the word on the memory bus is presented directly; if it
   // is not taken it is captured, so the beat stays stable while stalled.
   assign has_head   = (occ != 2'd0);
   assign head_valid = has_head || inflight;
   assign head_last  = has_head ? fifo_last[rd_ptr] : inflight_last;
   assign pop        = head_valid && m_axis_mem_read_data_ready;
   assign push       = inflight && !(!has_head && pop);
   assign fifo_pop   = pop && has_head;

   assign keep_last = (len_mod == '0) ? '1 : ((BYTES'(1) << len_mod) - BYTES'(1));

   assign m_axis_mem_read_data_valid = head_valid;
   assign m_axis_mem_read_data_data  = !head_valid ? '0 : (has_head ? fifo_data[rd_ptr] : mem_rd_data);
   assign m_axis_mem_read_data_keep  = !head_valid ? '0 : (head_last ? keep_last : '1);
   assign m_axis_mem_read_data_last  = head_valid && head_last;
   assign m_axis_mem_read_data_dest  = head_valid ? dest_q : '0;

   always_ff @(posedge net_clk) begin
      if (push) fifo_data[wr_ptr] <= mem_rd_data;
   end

   always_ff @(posedge net_clk or negedge net_aresetn) begin
      if (!net_aresetn) begin
         state                     <= IDLE;
         s_axis_mem_read_cmd_ready <= 1'b0;
         rd_addr                   <= '0;
         reads_left                <= '0;
         len_mod                   <= '0;
         dest_q                    <= '0;
         inflight                  <= 1'b0;
         inflight_last             <= 1'b0;
         fifo_last                 <= '0;
         wr_ptr                    <= 1'b0;
         rd_ptr                    <= 1'b0;
         occ                       <= '0;
         err_count                 <= '0;
`ifdef ROCE_RD_STATS_EN
         len_q                     <= '0;
         stat_cmd_count            <= '0;
         stat_byte_count           <= '0;
`endif
      end else begin
         if (push) begin
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (fifo_pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, fifo_pop};

         inflight      <= mem_rd_en;
         inflight_last <= mem_rd_en && (reads_left == BW'(1));
         if (mem_rd_en) begin
            rd_addr    <= rd_addr + 1'b1;
            reads_left <= reads_left - 1'b1;
         end

         unique case (state)
            IDLE: begin
               s_axis_mem_read_cmd_ready <= 1'b1;
               if (cmd_accept) begin
                  rd_addr    <= cmd_vaddr[MEM_AW+OFS-1:OFS];
                  reads_left <= cmd_beats;
                  len_mod    <= cmd_len[OFS-1:0];
                  dest_q     <= s_axis_mem_read_cmd_dest;
`ifdef ROCE_RD_STATS_EN
                  len_q      <= cmd_len;
`endif
                  if ((cmd_len == '0 || cmd_vaddr[OFS-1:0] != '0) && err_count != 16'hFFFF)
                     err_count <= err_count + 16'd1;
                  // Zero-length commands are consumed in place with no beats.
                  if (cmd_len != '0) begin
                     state                     <= READ;
                     s_axis_mem_read_cmd_ready <= 1'b0;
                  end
               end
            end
            READ: begin
               if (mem_rd_en && reads_left == BW'(1)) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && head_last) begin
                  state                     <= IDLE;
                  s_axis_mem_read_cmd_ready <= 1'b1;
`ifdef ROCE_RD_STATS_EN
                  stat_cmd_count            <= stat_cmd_count + 32'd1;
                  stat_byte_count           <= stat_byte_count + 48'(len_q);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
